// File: rtl/palette_lut.sv
// Double-buffered colour palette. Lookups are registered with 1-cycle latency and never stall.
// wr_ready is low while a commit waits for the frame edge or the post-swap copy runs.
module palette_lut #(
   parameter int INDEX_BITS   = 8,
   parameter int COLOR_BITS   = 16,
   parameter bit VSYNC_ACTIVE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] index,
   output logic [COLOR_BITS-1:0] color,
   input  logic                  v_sync,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [COLOR_BITS-1:0] wr_color,
   input  logic                  commit,
   output logic                  busy,
   output logic                  commit_done
);

   localparam int DEPTH = 1 << INDEX_BITS;

   typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  bank_sel;
   logic                  vs_prev;
   logic                  frame_edge;
   logic [INDEX_BITS-1:0] copy_cnt;
   logic                  wr_accept;
   logic                  copy_en;
   logic                  copy_last;
   logic                  swap;
   logic                  shadow_we;
   logic [INDEX_BITS-1:0] shadow_addr;
   logic [COLOR_BITS-1:0] shadow_dat;
   logic [COLOR_BITS-1:0] copy_rd;

   logic [COLOR_BITS-1:0] bank0 [DEPTH];
   logic [COLOR_BITS-1:0] bank1 [DEPTH];

   assign frame_edge = (v_sync == VSYNC_ACTIVE) && (vs_prev != VSYNC_ACTIVE);
   assign wr_ready   = (state == IDLE);
   assign busy       = (state != IDLE);
   assign wr_accept  = wr_valid && wr_ready;
   assign copy_en    = (state == COPY);
   assign copy_last  = copy_en && (copy_cnt == {INDEX_BITS{1'b1}});
   assign swap       = (state == PENDING) && frame_edge;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (commit) state_nxt = PENDING;
         PENDING: if (frame_edge) state_nxt = COPY;
         COPY:    if (copy_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_prev     <= !VSYNC_ACTIVE;
         bank_sel    <= 1'b0;
         copy_cnt    <= '0;
         commit_done <= 1'b0;
      end else begin
         vs_prev     <= v_sync;
         commit_done <= copy_last;
         if (swap) bank_sel <= !bank_sel;
         // Counter wraps to zero on the last entry, ready for the next commit.
         if (copy_en) copy_cnt <= copy_cnt + INDEX_BITS'(1);
      end
   end

   // Copy reads the (new) active bank, so lookups share the same source and are undisturbed.
   assign copy_rd     = bank_sel ? bank1[copy_cnt] : bank0[copy_cnt];
   assign shadow_we   = wr_accept || copy_en;
   assign shadow_addr = copy_en ? copy_cnt : wr_index;
   assign shadow_dat  = copy_en ? copy_rd : wr_color;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            bank0[i] <= '0;
            bank1[i] <= '0;
         end
      end else if (shadow_we) begin
         if (bank_sel) bank0[shadow_addr] <= shadow_dat;
         else          bank1[shadow_addr] <= shadow_dat;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) color <= '0;
      else        color <= bank_sel ? bank1[index] : bank0[index];
   end

endmodule

// File: tb/tb_palette_lut.sv
module tb_palette_lut;
   localparam int IB = 8;
   localparam int CB = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [IB-1:0] index;
   logic [CB-1:0] color;
   logic          v_sync;
   logic          wr_valid;
   logic          wr_ready;
   logic [IB-1:0] wr_index;
   logic [CB-1:0] wr_color;
   logic          commit;
   logic          busy;
   logic          commit_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   palette_lut #(.INDEX_BITS(IB), .COLOR_BITS(CB), .VSYNC_ACTIVE(1'b1)) dut (
      .clk(clk), .reset(reset), .index(index), .color(color), .v_sync(v_sync),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index), .wr_color(wr_color),
      .commit(commit), .busy(busy), .commit_done(commit_done)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_write(input logic [IB-1:0] idx, input logic [CB-1:0] val);
      wr_valid = 1'b1; wr_index = idx; wr_color = val;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; index = 8'h05; v_sync = 1'b0; wr_valid = 1'b0;
      wr_index = '0; wr_color = '0; commit = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (color !== 16'h0000 || wr_ready !== 1'b1 || busy !== 1'b0 || commit_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: color=%h wr_ready=%b busy=%b done=%b, want 0000 1 0 0",
                     color, wr_ready, busy, commit_done);
         end
      end
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (color !== 16'h0000 || wr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: color=%h wr_ready=%b busy=%b, want 0000 1 0",
                     color, wr_ready, busy);
         end
      end
   endtask

   task automatic test_first_commit();
      int n;
      index = 8'h05;
      do_write(8'h05, 16'hF00F);
      commit = 1'b1; tick(); commit = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (color !== 16'h0000 || busy !== 1'b1 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_hold: color=%h busy=%b wr_ready=%b, want 0000 1 0",
                     color, busy, wr_ready);
         end
      end
      v_sync = 1'b1;
      tick();
      n_checks++;
      if (color !== 16'h0000) begin
         n_fail++;
         $display("FAIL swap_edge_old_bank: color=%h, want 0000", color);
      end
      tick();
      v_sync = 1'b0;
      n_checks++;
      if (color !== 16'hF00F) begin
         n_fail++;
         $display("FAIL swap_new_bank: color=%h, want f00f", color);
      end
      n = 1;
      while (commit_done !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      n_checks++;
      if (n !== 256 || busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL commit_done_latency: cycles=%0d busy=%b wr_ready=%b, want 256 0 1",
                  n, busy, wr_ready);
      end
      tick();
      n_checks++;
      if (commit_done !== 1'b0) begin
         n_fail++;
         $display("FAIL commit_done_width: done=%b, want 0", commit_done);
      end
   endtask

   task automatic test_idle_boundary();
      index = 8'h05;
      v_sync = 1'b1; tick(); tick();
      v_sync = 1'b0; tick(); tick();
      n_checks++;
      if (color !== 16'hF00F || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_boundary: color=%h busy=%b, want f00f 0", color, busy);
      end
   endtask

   task automatic test_copy_sweep();
      logic [CB-1:0] exp_c;
      int bad;
      bad = 0;
      do_write(8'h06, 16'h0A0A);
      commit = 1'b1; tick(); commit = 1'b0;
      tick();
      v_sync = 1'b1; tick();
      for (int i = 0; i < 256; i++) begin
         index = i[IB-1:0];
         if (i == 10) v_sync = 1'b0;
         if (i == 20) v_sync = 1'b1;
         tick();
         exp_c = (i == 5) ? 16'hF00F : (i == 6) ? 16'h0A0A : 16'h0000;
         n_checks++;
         if (color !== exp_c || commit_done !== (i == 255)) begin
            n_fail++; bad++;
            if (bad < 8)
               $display("FAIL copy_sweep[%0d]: color=%h done=%b, want %h %b",
                        i, color, commit_done, exp_c, (i == 255));
         end
      end
      v_sync = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || commit_done !== 1'b0) begin
         n_fail++;
         $display("FAIL sweep_end_idle: busy=%b done=%b, want 0 0", busy, commit_done);
      end
   endtask

   task automatic test_same_cycle_commit();
      int pulses;
      pulses = 0;
      index = 8'h10;
      wr_valid = 1'b1; wr_index = 8'h10; wr_color = 16'h1234; commit = 1'b1;
      tick();
      wr_index = 8'h11; wr_color = 16'hBEEF;
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL same_cycle_pending: busy=%b wr_ready=%b, want 1 0", busy, wr_ready);
      end
      tick(); tick();
      v_sync = 1'b1; tick(); v_sync = 1'b0;
      for (int k = 0; k < 300; k++) begin
         commit = (k == 50);
         tick();
         if (commit_done === 1'b1) pulses++;
      end
      commit = 1'b0;
      n_checks++;
      if (pulses !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_commit: pulses=%0d busy=%b, want 1 0", pulses, busy);
      end
      n_checks++;
      if (color !== 16'h1234) begin
         n_fail++;
         $display("FAIL same_cycle_write: color=%h, want 1234", color);
      end
      index = 8'h11; tick();
      n_checks++;
      if (color !== 16'h0000) begin
         n_fail++;
         $display("FAIL write_while_busy: color=%h, want 0000", color);
      end
      index = 8'h05; tick();
      n_checks++;
      if (color !== 16'hF00F) begin
         n_fail++;
         $display("FAIL copy_preserved: color=%h, want f00f", color);
      end
   endtask

   task automatic test_reset_mid_copy();
      int pulses;
      pulses = 0;
      index = 8'h05;
      do_write(8'h20, 16'h7777);
      commit = 1'b1; tick(); commit = 1'b0;
      v_sync = 1'b1; tick(); v_sync = 1'b0;
      repeat (100) tick();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL copy_in_progress: busy=%b, want 1", busy);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (color !== 16'h0000 || busy !== 1'b0 || wr_ready !== 1'b1 || dut.bank_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: color=%h busy=%b wr_ready=%b bank_sel=%b, want 0000 0 1 0",
                  color, busy, wr_ready, dut.bank_sel);
      end
      @(negedge clk);
      tick();
      reset = 1'b1;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (commit_done === 1'b1 || busy !== 1'b0) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL abandoned_commit: bad_cycles=%0d, want 0", pulses);
      end
      reset = 1'b0; tick();
      index = 8'h03;
      wr_valid = 1'b1; wr_index = 8'h03; wr_color = 16'h5555; commit = 1'b1;
      reset = 1'b1;
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL first_edge_commit: busy=%b, want 1", busy);
      end
      v_sync = 1'b1; tick(); tick(); v_sync = 1'b0;
      n_checks++;
      if (color !== 16'h5555) begin
         n_fail++;
         $display("FAIL first_edge_write: color=%h, want 5555", color);
      end
   endtask

   initial begin
      test_reset();
      test_first_commit();
      test_idle_boundary();
      test_copy_sweep();
      test_same_cycle_commit();
      test_reset_mid_copy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
